// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port memory arbiter: state encoding, port indices, default widths.
package mem_arb_pkg;

  localparam int DATA_W_DEF       = 256;
  localparam int ADDR_W_DEF       = 32;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int STARVE_W         = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between icache (port 0) and dcache (port 1).
// MEM_ARB_RR_EN selects round-robin tie-breaking; otherwise fixed priority with a starvation override.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
`ifdef MEM_ARB_RR_EN
  input  logic last_grant,
`else
  input  logic starve_hit,
`endif
  output logic winner
);

  always_comb begin
    winner = PORT_D;
    if (req0 && !req1) begin
      winner = PORT_I;
    end else if (req0 && req1) begin
`ifdef MEM_ARB_RR_EN
      winner = ~last_grant;
`else
      winner = starve_hit ? PORT_I : PORT_D;
`endif
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one line-wide memory interface between icache and dcache.
// Optional MEM_ARB_RR_EN: round-robin ties instead of fixed priority plus starvation counter.
//
// state      | meaning
// IDLE       | sample requests, latch winner's write/addr/data
// BUSY       | memory transaction in flight, outputs held until mem_ack_i
// RECOVER    | one dead cycle so the requester can drop req
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_req_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic              p0_ack_o,
  output logic [DATA_W-1:0] p0_data_o,
  input  logic              p1_req_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic              p1_ack_o,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              grant_o,
  output logic              busy_o
);

  logic [1:0] state;
  logic       grant_q;
  logic       winner;
  logic       any_req;
  logic       in_busy;

  assign any_req = p0_req_i | p1_req_i;
  assign in_busy = (state == ST_BUSY);

  assign busy_o    = in_busy;
  assign grant_o   = grant_q;
  assign p0_ack_o  = mem_ack_i & in_busy & (grant_q == PORT_I);
  assign p1_ack_o  = mem_ack_i & in_busy & (grant_q == PORT_D);
  assign p0_data_o = mem_data_i;
  assign p1_data_o = mem_data_i;

`ifdef MEM_ARB_RR_EN
  mem_arb_pick u_pick (
    .req0       (p0_req_i),
    .req1       (p1_req_i),
    .last_grant (grant_q),
    .winner     (winner)
  );
`else
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt;
  logic                starve_hit;

  assign starve_hit = (starve_cnt == STARVE_MAX);

  mem_arb_pick u_pick (
    .req0       (p0_req_i),
    .req1       (p1_req_i),
    .starve_hit (starve_hit),
    .winner     (winner)
  );

  // Counts consecutive dcache wins over a waiting icache; saturates at the limit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      starve_cnt <= '0;
    end else if (state == ST_IDLE && any_req) begin
      if (winner == PORT_I) begin
        starve_cnt <= '0;
      end else if (p0_req_i && !starve_hit) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= ST_IDLE;
      grant_q      <= PORT_I;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state        <= ST_BUSY;
            grant_q      <= winner;
            mem_enable_o <= 1'b1;
            mem_write_o  <= winner ? p1_write_i : p0_write_i;
            mem_addr_o   <= winner ? p1_addr_i  : p0_addr_i;
            mem_data_o   <= winner ? p1_data_i  : p0_data_i;
          end
        end
        ST_BUSY: begin
          if (mem_ack_i) begin
            state        <= ST_RECOVER;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
          end
        end
        ST_RECOVER: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
